// File: rtl/dot_product_accumulator_if.sv
// Term-in / result-out handshake bundle for dot_product_accumulator.
// The accumulator connects to the slave modport, and the term producer / result consumer connects to the master modport.
interface dot_product_accumulator_if #(
  parameter int BIT_WIDTH = 16,
  parameter int CNT_W     = 3
);
  logic                 term_valid;
  logic                 term_ready;
  logic [BIT_WIDTH-1:0] term_data;
  logic                 term_sub;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] out_data;
  logic                 out_overflow;
  logic [CNT_W-1:0]     acc_count;

  modport master (
    output term_valid, term_data, term_sub, out_ready,
    input  term_ready, out_valid, out_data, out_overflow, acc_count
  );

  modport slave (
    input  term_valid, term_data, term_sub, out_ready,
    output term_ready, out_valid, out_data, out_overflow, acc_count
  );
endinterface

// File: rtl/dot_product_accumulator.sv
// Signed add/sub accumulator: sums VEC_LEN terms into one result with a sticky overflow flag.
// Optional macro ACC_SAT_EN saturates the accumulator on overflow instead of wrapping.
module dot_product_accumulator #(
  parameter int BIT_WIDTH = 16,
  parameter int VEC_LEN   = 4,
  parameter int CNT_W     = $clog2(VEC_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  dot_product_accumulator_if.slave bus,
  output logic                     dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the sender holds data stable while valid is high and not yet
  // accepted, and ready never depends on valid.
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [BIT_WIDTH-1:0] ACC_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0] ACC_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};
  localparam int                   MSB     = BIT_WIDTH - 1;

  state_t               state_q, state_d;
  logic [BIT_WIDTH-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0]     count_q;
  logic                 ovf_q, step_ovf;
  logic                 ready, accept, handoff, last_term;

  assign ready     = rst_n & ~clear & (state_q == ACCUM);
  assign accept    = ready & bus.term_valid;
  assign handoff   = (state_q == HOLD) & bus.out_ready;
  assign last_term = (count_q == CNT_W'(VEC_LEN - 1));

  always_comb begin
    sum      = bus.term_sub ? (acc_q - bus.term_data) : (acc_q + bus.term_data);
    step_ovf = 1'b0;
    if (bus.term_sub)
      step_ovf = (acc_q[MSB] != bus.term_data[MSB]) && (sum[MSB] != acc_q[MSB]);
    else
      step_ovf = (acc_q[MSB] == bus.term_data[MSB]) && (sum[MSB] != acc_q[MSB]);
    acc_d = sum;
`ifdef ACC_SAT_EN
    // Direction of the true (unbounded) result picks the rail.
    if (step_ovf)
      acc_d = (~acc_q[MSB] & (~bus.term_sub | bus.term_data[MSB])) ? ACC_MAX : ACC_MIN;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && last_term) state_d = HOLD;
      HOLD:    if (bus.out_ready)       state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
    if (clear) state_d = ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clear || handoff) begin
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      acc_q   <= acc_d;
      count_q <= count_q + CNT_W'(1);
      ovf_q   <= ovf_q | step_ovf;
    end
  end

  assign bus.term_ready   = ready;
  assign bus.out_valid    = (state_q == HOLD);
  assign bus.out_data     = acc_q;
  assign bus.out_overflow = ovf_q;
  assign bus.acc_count    = count_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Randomized and directed bench for dot_product_accumulator against an
// integer-arithmetic reference model of the running signed sum.
module tb_dot_product_accumulator;

  localparam int BIT_WIDTH = 16;
  localparam int VEC_LEN   = 4;
  localparam int CNT_W     = $clog2(VEC_LEN + 1);

  logic clk;
  logic rst_n;
  logic clear;
  logic dbg_state;

  dot_product_accumulator_if #(.BIT_WIDTH(BIT_WIDTH), .CNT_W(CNT_W)) bus ();

  dot_product_accumulator #(
    .BIT_WIDTH(BIT_WIDTH),
    .VEC_LEN  (VEC_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: exact integer sum per step, then wrap or saturate
  int   m_acc   = 0;
  int   m_count = 0;
  bit   m_ovf   = 1'b0;
  logic [BIT_WIDTH:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc   = 0;
    m_count = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_add(input logic [BIT_WIDTH-1:0] d, input logic s);
    int t, exact;
    logic [BIT_WIDTH-1:0] bits;
    t     = int'($signed(d));
    exact = s ? (m_acc - t) : (m_acc + t);
    if (exact > 32767 || exact < -32768) begin
      m_ovf = 1'b1;
`ifdef ACC_SAT_EN
      exact = (exact > 0) ? 32767 : -32768;
`else
      exact = (exact > 0) ? exact - 65536 : exact + 65536;
`endif
    end
    m_acc = exact;
    m_count++;
    if (m_count == VEC_LEN) begin
      bits = m_acc[BIT_WIDTH-1:0];
      exp_q.push_back({m_ovf, bits});
    end
  endtask

  // driver tasks: all start and end at posedge + #1
  task automatic idle_cycle();
    @(negedge clk);
    check("ready_idle", {31'd0, bus.term_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic put_term(input logic [BIT_WIDTH-1:0] d, input logic s);
    bus.term_valid = 1'b1;
    bus.term_data  = d;
    bus.term_sub   = s;
    @(negedge clk);
    check("term_ready", {31'd0, bus.term_ready}, 32'd1);
    check("acc_count_run", 32'(bus.acc_count), 32'(m_count));
    @(posedge clk); #1;
    bus.term_valid = 1'b0;
    model_add(d, s);
  endtask

  task automatic put_vec(input logic [BIT_WIDTH-1:0] d0, input logic [BIT_WIDTH-1:0] d1,
                         input logic [BIT_WIDTH-1:0] d2, input logic [BIT_WIDTH-1:0] d3,
                         input logic [3:0] subs);
    put_term(d0, subs[0]);
    put_term(d1, subs[1]);
    put_term(d2, subs[2]);
    put_term(d3, subs[3]);
  endtask

  // scoreboard side: result must appear the cycle after the last accept
  task automatic take_result(input int hold);
    logic [BIT_WIDTH:0] exp;
    @(negedge clk);
    check("out_valid_latency", {31'd0, bus.out_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    check("out_data", 32'(bus.out_data), 32'(exp[BIT_WIDTH-1:0]));
    check("out_overflow", {31'd0, bus.out_overflow}, {31'd0, exp[BIT_WIDTH]});
    check("acc_count_hold", 32'(bus.acc_count), VEC_LEN);
    bus.term_valid = 1'b1;
    bus.term_data  = BIT_WIDTH'($urandom);
    bus.term_sub   = 1'($urandom);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_ready", {31'd0, bus.term_ready}, 32'd0);
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_data", 32'(bus.out_data), 32'(exp[BIT_WIDTH-1:0]));
      check("hold_count", 32'(bus.acc_count), VEC_LEN);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready  = 1'b0;
    bus.term_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check("post_valid", {31'd0, bus.out_valid}, 32'd0);
    check("post_count", 32'(bus.acc_count), 32'd0);
    check("post_ovf", {31'd0, bus.out_overflow}, 32'd0);
    check("post_ready", {31'd0, bus.term_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_data"}, 32'(bus.out_data), 32'd0);
    check({tag, "_ovf"}, {31'd0, bus.out_overflow}, 32'd0);
    check({tag, "_count"}, 32'(bus.acc_count), 32'd0);
    check({tag, "_ready"}, {31'd0, bus.term_ready}, 32'd0);
  endtask

  initial begin
    logic [BIT_WIDTH-1:0] d [4];
    logic [3:0] subs;
    rst_n          = 1'b0;
    clear          = 1'b0;
    bus.term_valid = 1'b0;
    bus.term_data  = '0;
    bus.term_sub   = 1'b0;
    bus.out_ready  = 1'b0;
    #2;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // basic sum 1+2+3+4
    put_vec(16'd1, 16'd2, 16'd3, 16'd4, 4'b0000);
    take_result(0);
    // positive overflow
    put_vec(16'h7000, 16'h2000, 16'h0000, 16'h0000, 4'b0000);
    take_result(1);
    // mixed add/sub going negative
    put_vec(16'd5, 16'd8, 16'd1, 16'd0, 4'b0010);
    take_result(0);
    // subtracting the most negative value from zero
    put_vec(16'h8000, 16'h0000, 16'h0000, 16'h0000, 4'b0001);
    take_result(2);
    // long backpressure with terms offered
    put_vec(16'd10, 16'd20, 16'd30, 16'd40, 4'b0100);
    take_result(5);

    // clear mid-accumulation drops the term offered alongside it
    put_term(16'd3, 1'b0);
    put_term(16'd3, 1'b0);
    clear          = 1'b1;
    bus.term_valid = 1'b1;
    bus.term_data  = 16'd3;
    @(negedge clk);
    check("clear_ready", {31'd0, bus.term_ready}, 32'd0);
    @(posedge clk); #1;
    clear          = 1'b0;
    bus.term_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check("clear_count", 32'(bus.acc_count), 32'd0);
    check("clear_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    put_vec(16'd1, 16'd1, 16'd1, 16'd1, 4'b0000);
    take_result(0);

    // clear while a result is pending discards it
    put_vec(16'h7fff, 16'h7fff, 16'd2, 16'd3, 4'b0000);
    void'(exp_q.pop_back());
    @(negedge clk);
    check("pend_valid", {31'd0, bus.out_valid}, 32'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
    @(negedge clk);
    check("pend_clr_valid", {31'd0, bus.out_valid}, 32'd0);
    check("pend_clr_ovf", {31'd0, bus.out_overflow}, 32'd0);
    check("pend_clr_count", 32'(bus.acc_count), 32'd0);
    @(posedge clk); #1;

    // async reset mid-accumulation with overflow already flagged
    put_term(16'h7000, 1'b0);
    put_term(16'h2000, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    put_vec(16'd7, 16'd9, 16'd2, 16'd1, 4'b1000);
    take_result(0);

    // async reset during HOLD
    put_vec(16'd100, 16'd200, 16'd300, 16'd400, 4'b0000);
    void'(exp_q.pop_back());
    @(negedge clk);
    check("rst_hold_pre", {31'd0, bus.out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_values("rst_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    idle_cycle();

    // randomized vectors with random gaps and backpressure
    for (int v = 0; v < 40; v++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0:       d[k] = BIT_WIDTH'($urandom_range(0, 15));
          1:       d[k] = BIT_WIDTH'($urandom_range(16'h7ff0, 16'h8010));
          default: d[k] = BIT_WIDTH'($urandom);
        endcase
      end
      subs = 4'($urandom);
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) idle_cycle();
        put_term(d[k], subs[k]);
      end
      take_result($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
